// File: rtl/work_pkg.sv
// Shared types and widths for the work dispatcher block.
package work_pkg;

   localparam int NONCE_W       = 32;
   localparam int MIDSTATE_W    = 256;
   localparam int DATA_W        = 96;
   localparam int TAG_W_DEFAULT = 4;

   typedef enum logic {
      DISP_IDLE,
      DISP_RUN
   } disp_state_t;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_HOLD,
      SEQ_GAP
   } seq_state_t;

endpackage

// File: rtl/work_dispatcher_if.sv
// Job, hash-pipeline and golden-ticket signals of the work dispatcher.
interface work_dispatcher_if #(
   parameter int TAG_W = work_pkg::TAG_W_DEFAULT
) ();
   import work_pkg::*;

   logic                  new_work;
   logic [MIDSTATE_W-1:0] midstate;
   logic [DATA_W-1:0]     work_data;
   logic [NONCE_W-1:0]    nonce_min;
   logic [NONCE_W-1:0]    nonce_max;

   logic                  job_valid;
   logic                  job_ready;
   logic [NONCE_W-1:0]    job_nonce;
   logic [MIDSTATE_W-1:0] job_midstate;
   logic [DATA_W-1:0]     job_data;
   logic [TAG_W-1:0]      job_tag;

   logic                  hit_valid;
   logic [NONCE_W-1:0]    hit_nonce;
   logic [TAG_W-1:0]      hit_tag;

   logic                  new_golden_ticket;
   logic [NONCE_W-1:0]    golden_nonce;
   logic                  need_work;
   logic [7:0]            hits_dropped;

   modport master (
      input  new_work, midstate, work_data, nonce_min, nonce_max,
      input  job_ready, hit_valid, hit_nonce, hit_tag,
      output job_valid, job_nonce, job_midstate, job_data, job_tag,
      output new_golden_ticket, golden_nonce, need_work, hits_dropped
   );

   modport slave (
      output new_work, midstate, work_data, nonce_min, nonce_max,
      output job_ready, hit_valid, hit_nonce, hit_tag,
      input  job_valid, job_nonce, job_midstate, job_data, job_tag,
      input  new_golden_ticket, golden_nonce, need_work, hits_dropped
   );

endinterface

// File: rtl/golden_hit_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module golden_hit_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             hash_clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             wr_en;
   logic             rd_en;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full     = (cnt == CNT_W'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign pop_data = mem[rd_ptr];
   assign rd_en    = pop && !empty;
   assign wr_en    = push && (!full || rd_en);

   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (rd_en) rd_ptr <= bump(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/work_dispatcher.sv
// Walks each job's inclusive nonce range onto the hash pipeline and turns
// tag-matched hits into held golden tickets for the slower UART clock domain.
module work_dispatcher
   import work_pkg::*;
#(
   parameter int TAG_W       = TAG_W_DEFAULT,
   parameter int HIT_DEPTH   = 4,
   parameter int TICKET_HOLD = 8
) (
   input  logic              hash_clk,
   input  logic              rst_n,
   work_dispatcher_if.master bus
);

   localparam int CNT_W   = $clog2(HIT_DEPTH + 1);
   localparam int TIMER_W = $clog2(TICKET_HOLD + 1);

   disp_state_t           state_q, state_d;
   logic                  valid_q, valid_d;
   logic [NONCE_W-1:0]    cur_q, cur_d;
   logic [NONCE_W-1:0]    end_q, end_d;
   logic [TAG_W-1:0]      tag_q, tag_d;
   logic [MIDSTATE_W-1:0] mid_q, mid_d;
   logic [DATA_W-1:0]     data_q, data_d;

   seq_state_t            seq_q, seq_d;
   logic [TIMER_W-1:0]    timer_q, timer_d;
   logic                  ticket_q, ticket_d;
   logic [NONCE_W-1:0]    golden_q, golden_d;
   logic [7:0]            dropped_q;

   logic                  pop;
   logic                  push;
   logic                  drop;
   logic                  tag_match;
   logic [NONCE_W-1:0]    fifo_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;

   assign bus.job_valid         = valid_q;
   assign bus.job_nonce         = cur_q;
   assign bus.job_tag           = tag_q;
   assign bus.job_midstate      = mid_q;
   assign bus.job_data          = data_q;
   assign bus.need_work         = (state_q == DISP_IDLE);
   assign bus.new_golden_ticket = ticket_q;
   assign bus.golden_nonce      = golden_q;
   assign bus.hits_dropped      = dropped_q;

   // A new job always wins the state update and forces one cycle of invalid
   // output while the freshly loaded fields settle.
   always_comb begin
      state_d = state_q;
      valid_d = 1'b0;
      cur_d   = cur_q;
      end_d   = end_q;
      tag_d   = tag_q;
      mid_d   = mid_q;
      data_d  = data_q;
      if (bus.new_work) begin
         mid_d   = bus.midstate;
         data_d  = bus.work_data;
         end_d   = bus.nonce_max;
         cur_d   = bus.nonce_min;
         tag_d   = tag_q + TAG_W'(1);
         state_d = (bus.nonce_min <= bus.nonce_max) ? DISP_RUN : DISP_IDLE;
      end else if (state_q == DISP_RUN) begin
         valid_d = 1'b1;
         if (valid_q && bus.job_ready) begin
            if (cur_q == end_q) begin
               state_d = DISP_IDLE;
               valid_d = 1'b0;
            end else begin
               cur_d = cur_q + NONCE_W'(1);
            end
         end
      end
   end

   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DISP_IDLE;
         valid_q <= 1'b0;
         cur_q   <= '0;
         end_q   <= '0;
         tag_q   <= '0;
         mid_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         cur_q   <= cur_d;
         end_q   <= end_d;
         tag_q   <= tag_d;
         mid_q   <= mid_d;
         data_q  <= data_d;
      end
   end

   // Back-to-back tickets pop straight out of the last gap cycle so the low
   // gap is exactly TICKET_HOLD cycles.
   always_comb begin
      seq_d    = seq_q;
      timer_d  = timer_q;
      ticket_d = ticket_q;
      golden_d = golden_q;
      pop      = 1'b0;
      case (seq_q)
         SEQ_IDLE: pop = !fifo_empty;
         SEQ_HOLD: begin
            if (timer_q == '0) begin
               seq_d    = SEQ_GAP;
               ticket_d = 1'b0;
               timer_d  = TIMER_W'(TICKET_HOLD - 1);
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         SEQ_GAP: begin
            if (timer_q == '0) begin
               pop   = !fifo_empty;
               seq_d = SEQ_IDLE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: seq_d = SEQ_IDLE;
      endcase
      if (pop) begin
         seq_d    = SEQ_HOLD;
         ticket_d = 1'b1;
         timer_d  = TIMER_W'(TICKET_HOLD - 1);
         golden_d = fifo_data;
      end
   end

   assign tag_match = bus.hit_valid && (bus.hit_tag == tag_q);
   assign push      = tag_match && ((fifo_count < CNT_W'(HIT_DEPTH)) || pop);
   assign drop      = bus.hit_valid && (!tag_match || (fifo_full && !pop));

   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q     <= SEQ_IDLE;
         timer_q   <= '0;
         ticket_q  <= 1'b0;
         golden_q  <= '0;
         dropped_q <= '0;
      end else begin
         seq_q    <= seq_d;
         timer_q  <= timer_d;
         ticket_q <= ticket_d;
         golden_q <= golden_d;
         if (drop && (dropped_q != 8'hFF)) dropped_q <= dropped_q + 8'd1;
      end
   end

   golden_hit_fifo #(
      .DEPTH (HIT_DEPTH),
      .WIDTH (NONCE_W)
   ) u_hit_fifo (
      .hash_clk  (hash_clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (bus.hit_nonce),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule
